rect_plotter: RTL and testbench

Pixel-drawing responder for the game's draw controller. It accepts one rectangle request (origin, size, colour), walks it row-major one pixel per clock, and drives the VGA adapter's plot/x/y/colour inputs. It signals completion so the controller can advance to its next draw state, such as wall to bird. Pixels outside the screen are clipped.

---
 rtl/rect_plotter_if.sv | 39 +++
 rtl/rect_plotter.sv | 169 ++++++++++++++++
 tb/tb_rect_plotter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rect_plotter_if.sv
// Request/pixel bundle between the draw controller and rect_plotter.
// RECT_OUTLINE_EN adds the outline_in request field.
interface rect_plotter_if #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
);
    logic                req;
    logic [X_W-1:0]      x_in;
    logic [Y_W-1:0]      y_in;
    logic [X_W-1:0]      w_in;
    logic [Y_W-1:0]      h_in;
    logic [COLOUR_W-1:0] colour_in;
`ifdef RECT_OUTLINE_EN
    logic                outline_in;
`endif
    logic                busy;
    logic                done;
    logic                plot;
    logic [X_W-1:0]      x_out;
    logic [Y_W-1:0]      y_out;
    logic [COLOUR_W-1:0] colour_out;

    modport master (
        output req, x_in, y_in, w_in, h_in, colour_in,
`ifdef RECT_OUTLINE_EN
        output outline_in,
`endif
        input  busy, done, plot, x_out, y_out, colour_out
    );

    modport slave (
        input  req, x_in, y_in, w_in, h_in, colour_in,
`ifdef RECT_OUTLINE_EN
        input  outline_in,
`endif
        output busy, done, plot, x_out, y_out, colour_out
    );
endinterface

// File: rtl/rect_plotter.sv
// Rectangle fill walker: one pixel per clock, row-major, off-screen pixels clipped.
// Optional macro RECT_OUTLINE_EN restricts plotting to the rectangle perimeter.
module rect_plotter #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic          clk,
    input  logic          resetn,
    rect_plotter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    localparam logic [X_W:0]   SCREEN_W_L = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0]   SCREEN_H_L = (Y_W+1)'(SCREEN_H);
    localparam logic [X_W-1:0] X_ONE      = X_W'(1);
    localparam logic [Y_W-1:0] Y_ONE      = Y_W'(1);

    state_t              state_reg, state_next;
    logic [X_W-1:0]      x0_reg, x0_next;
    logic [Y_W-1:0]      y0_reg, y0_next;
    logic [X_W-1:0]      w_reg, w_next;
    logic [Y_W-1:0]      h_reg, h_next;
    logic [COLOUR_W-1:0] colour_reg, colour_next;
    logic [X_W-1:0]      col_reg, col_next;
    logic [Y_W-1:0]      row_reg, row_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic                plot_reg, plot_next;
    logic [X_W-1:0]      x_out_reg, x_out_next;
    logic [Y_W-1:0]      y_out_reg, y_out_next;
    logic [COLOUR_W-1:0] colour_out_reg, colour_out_next;
`ifdef RECT_OUTLINE_EN
    logic                outline_reg, outline_next;
    logic                on_edge;
`endif

    logic                last_col;
    logic                last_row;
    logic [X_W:0]        sum_x;
    logic [Y_W:0]        sum_y;

    assign last_col = (col_reg == w_reg - X_ONE);
    assign last_row = (row_reg == h_reg - Y_ONE);

    // Outputs are computed from the *next* pixel so the accepted pixel 0
    // is already on the registered outputs in the cycle after accept.
    always_comb begin
        state_next  = state_reg;
        x0_next     = x0_reg;
        y0_next     = y0_reg;
        w_next      = w_reg;
        h_next      = h_reg;
        colour_next = colour_reg;
        col_next    = col_reg;
        row_next    = row_reg;
`ifdef RECT_OUTLINE_EN
        outline_next = outline_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (bus.req) begin
                    x0_next     = bus.x_in;
                    y0_next     = bus.y_in;
                    w_next      = bus.w_in;
                    h_next      = bus.h_in;
                    colour_next = bus.colour_in;
`ifdef RECT_OUTLINE_EN
                    outline_next = bus.outline_in;
`endif
                    col_next    = '0;
                    row_next    = '0;
                    state_next  = (bus.w_in == '0 || bus.h_in == '0) ? DONE : DRAW;
                end
            end
            DRAW: begin
                if (last_col && last_row) begin
                    state_next = DONE;
                end else if (last_col) begin
                    col_next = '0;
                    row_next = row_reg + Y_ONE;
                end else begin
                    col_next = col_reg + X_ONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // One extra bit keeps the clip test honest when the sum wraps the port width.
        sum_x = {1'b0, x0_next} + {1'b0, col_next};
        sum_y = {1'b0, y0_next} + {1'b0, row_next};

        plot_next = (state_next == DRAW) && (sum_x < SCREEN_W_L) && (sum_y < SCREEN_H_L);
`ifdef RECT_OUTLINE_EN
        on_edge = (col_next == '0) || (row_next == '0) ||
                  (col_next == w_next - X_ONE) || (row_next == h_next - Y_ONE);
        if (outline_next && !on_edge) begin
            plot_next = 1'b0;
        end
`endif

        x_out_next      = x_out_reg;
        y_out_next      = y_out_reg;
        colour_out_next = colour_out_reg;
        if (state_next == DRAW) begin
            x_out_next      = sum_x[X_W-1:0];
            y_out_next      = sum_y[Y_W-1:0];
            colour_out_next = colour_next;
        end

        busy_next = (state_next != IDLE);
        done_next = (state_next == DONE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            x0_reg         <= '0;
            y0_reg         <= '0;
            w_reg          <= '0;
            h_reg          <= '0;
            colour_reg     <= '0;
            col_reg        <= '0;
            row_reg        <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            plot_reg       <= 1'b0;
            x_out_reg      <= '0;
            y_out_reg      <= '0;
            colour_out_reg <= '0;
`ifdef RECT_OUTLINE_EN
            outline_reg    <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            x0_reg         <= x0_next;
            y0_reg         <= y0_next;
            w_reg          <= w_next;
            h_reg          <= h_next;
            colour_reg     <= colour_next;
            col_reg        <= col_next;
            row_reg        <= row_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            plot_reg       <= plot_next;
            x_out_reg      <= x_out_next;
            y_out_reg      <= y_out_next;
            colour_out_reg <= colour_out_next;
`ifdef RECT_OUTLINE_EN
            outline_reg    <= outline_next;
`endif
        end
    end

    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.plot       = plot_reg;
    assign bus.x_out      = x_out_reg;
    assign bus.y_out      = y_out_reg;
    assign bus.colour_out = colour_out_reg;
endmodule

// File: tb/tb_rect_plotter.sv
// Bench for rect_plotter: per-cycle expectation table built from rectangle arithmetic,
// plus literal pins on selected cycles. Set RECT_OUTLINE_EN to cover the outline mode.
module tb_rect_plotter;
    localparam int K_IDLE = 0;
    localparam int K_PIX  = 1;
    localparam int K_DONE = 2;
    localparam int K_RST  = 3;
    localparam int DEPTH  = 4096;

    typedef struct {
        int kind;
        int x;
        int y;
        int c;
        bit p;
    } exp_t;

    typedef struct {
        bit x_en;
        int x;
        bit y_en;
        int y;
        bit d_en;
        bit d;
        bit p_en;
        bit p;
    } lit_t;

    logic clk;
    logic resetn;
    int   edge_cnt;
    int   n_checks;
    int   n_fail;
    exp_t tab [0:DEPTH-1];
    lit_t lit [0:DEPTH-1];

    rect_plotter_if #(.X_W(8), .Y_W(7), .COLOUR_W(3)) bus ();

    rect_plotter #(
        .X_W(8), .Y_W(7), .COLOUR_W(3), .SCREEN_W(160), .SCREEN_H(120)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        edge_cnt = 0;
        forever begin
            @(posedge clk);
            edge_cnt = edge_cnt + 1;
        end
    end

    task automatic chk(string nm, int act, int exp);
        n_checks = n_checks + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, edge_cnt, act, exp);
        end
    endtask

    // Single checker: every cycle, DUT outputs against the expectation table.
    initial begin
        int hold_x;
        int hold_y;
        int cyc;
        n_checks = 0;
        n_fail   = 0;
        hold_x   = 0;
        hold_y   = 0;
        forever begin
            @(negedge clk);
            cyc = edge_cnt;
            if (cyc >= 1 && cyc < DEPTH) begin
                case (tab[cyc].kind)
                    K_RST: begin
                        chk("rst_busy", int'(bus.busy), 0);
                        chk("rst_done", int'(bus.done), 0);
                        chk("rst_plot", int'(bus.plot), 0);
                        chk("rst_x", int'(bus.x_out), 0);
                        chk("rst_y", int'(bus.y_out), 0);
                        chk("rst_colour", int'(bus.colour_out), 0);
                        hold_x = 0;
                        hold_y = 0;
                    end
                    K_PIX: begin
                        chk("pix_busy", int'(bus.busy), 1);
                        chk("pix_done", int'(bus.done), 0);
                        chk("pix_plot", int'(bus.plot), int'(tab[cyc].p));
                        chk("pix_x", int'(bus.x_out), tab[cyc].x);
                        chk("pix_y", int'(bus.y_out), tab[cyc].y);
                        chk("pix_colour", int'(bus.colour_out), tab[cyc].c);
                        hold_x = tab[cyc].x;
                        hold_y = tab[cyc].y;
                    end
                    K_DONE: begin
                        chk("done_busy", int'(bus.busy), 1);
                        chk("done_done", int'(bus.done), 1);
                        chk("done_plot", int'(bus.plot), 0);
                        chk("done_xhold", int'(bus.x_out), hold_x);
                        chk("done_yhold", int'(bus.y_out), hold_y);
                    end
                    default: begin
                        chk("idle_busy", int'(bus.busy), 0);
                        chk("idle_done", int'(bus.done), 0);
                        chk("idle_plot", int'(bus.plot), 0);
                        chk("idle_xhold", int'(bus.x_out), hold_x);
                        chk("idle_yhold", int'(bus.y_out), hold_y);
                    end
                endcase
                if (lit[cyc].x_en) chk("lit_x", int'(bus.x_out), lit[cyc].x);
                if (lit[cyc].y_en) chk("lit_y", int'(bus.y_out), lit[cyc].y);
                if (lit[cyc].d_en) chk("lit_done", int'(bus.done), int'(lit[cyc].d));
                if (lit[cyc].p_en) chk("lit_plot", int'(bus.plot), int'(lit[cyc].p));
            end
        end
    end

    // Expected trace of one accepted request: pixel k in cycle a+k, done in cycle a+w*h.
    task automatic model_req(int a, int x, int y, int w, int h, int c, bit outl);
        int n;
        int col;
        int row;
        int sx;
        int sy;
        n = w * h;
        for (int k = 0; k < n; k++) begin
            col = k % w;
            row = k / w;
            sx  = x + col;
            sy  = y + row;
            tab[a+k].kind = K_PIX;
            tab[a+k].x    = sx % 256;
            tab[a+k].y    = sy % 128;
            tab[a+k].c    = c;
            tab[a+k].p    = (sx < 160) && (sy < 120) &&
                            (!outl || row == 0 || row == h-1 || col == 0 || col == w-1);
        end
        tab[a+n].kind = K_DONE;
    endtask

    task automatic drive_inputs(int x, int y, int w, int h, int c, bit outl);
        bus.x_in      = 8'(x);
        bus.y_in      = 7'(y);
        bus.w_in      = 8'(w);
        bus.h_in      = 7'(h);
        bus.colour_in = 3'(c);
`ifdef RECT_OUTLINE_EN
        bus.outline_in = outl;
`else
        if (outl) $display("note: outline request issued without RECT_OUTLINE_EN");
`endif
    endtask

    // Called at a falling edge while the DUT is idle; returns the cycle of pixel 0.
    task automatic issue(int x, int y, int w, int h, int c, bit outl, output int a);
        drive_inputs(x, y, w, h, c, outl);
        bus.req = 1'b1;
        a = edge_cnt + 1;
        model_req(a, x, y, w, h, c, outl);
        @(negedge clk);
        bus.req = 1'b0;
        drive_inputs(x ^ 8'hA5, y ^ 7'h2B, w ^ 8'h0F, h ^ 7'h03, c ^ 3'h7, !outl);
        $display("req x=%0d y=%0d w=%0d h=%0d colour=%0d outline=%0d accepted at edge %0d",
                 x, y, w, h, c, outl, a);
    endtask

    task automatic pulse_reset(int cycles);
        int e;
        resetn = 1'b0;
        e = edge_cnt + 1;
        for (int i = e; i < DEPTH; i++) tab[i].kind = K_IDLE;
        for (int j = 0; j < cycles; j++) tab[e+j].kind = K_RST;
        repeat (cycles) @(negedge clk);
        resetn = 1'b1;
        $display("reset held for %0d edges from edge %0d", cycles, e);
    endtask

    task automatic wait_until(int c);
        while (edge_cnt < c) @(negedge clk);
    endtask

    task automatic lit_x(int cyc, int v);
        lit[cyc].x_en = 1'b1;
        lit[cyc].x    = v;
    endtask
    task automatic lit_y(int cyc, int v);
        lit[cyc].y_en = 1'b1;
        lit[cyc].y    = v;
    endtask
    task automatic lit_d(int cyc, bit v);
        lit[cyc].d_en = 1'b1;
        lit[cyc].d    = v;
    endtask
    task automatic lit_p(int cyc, bit v);
        lit[cyc].p_en = 1'b1;
        lit[cyc].p    = v;
    endtask

    initial begin
        int a;
        int a2;
        for (int i = 0; i < DEPTH; i++) begin
            tab[i] = '{kind: K_IDLE, x: 0, y: 0, c: 0, p: 1'b0};
            lit[i] = '{x_en: 1'b0, x: 0, y_en: 1'b0, y: 0, d_en: 1'b0, d: 1'b0, p_en: 1'b0, p: 1'b0};
        end
        bus.req = 1'b0;
        drive_inputs(0, 0, 0, 0, 0, 1'b0);
        pulse_reset(3);
        repeat (2) @(negedge clk);

        // Fill 2x2 at (10,20)
        issue(10, 20, 2, 2, 4, 1'b0, a);
        lit_x(a, 10);   lit_y(a, 20);  lit_p(a, 1'b1);
        lit_x(a+1, 11);
        lit_x(a+2, 10); lit_y(a+2, 21);
        lit_x(a+3, 11); lit_y(a+3, 21);
        lit_d(a+3, 1'b0);
        lit_d(a+4, 1'b1);
        lit_d(a+5, 1'b0);
        wait_until(a + 6);

        // Clip at the bottom-right corner
        issue(158, 119, 4, 2, 2, 1'b0, a);
        lit_p(a, 1'b1); lit_p(a+1, 1'b1); lit_p(a+2, 1'b0); lit_p(a+4, 1'b0);
        lit_x(a+3, 161); lit_x(a+7, 161); lit_y(a+7, 120);
        lit_d(a+8, 1'b1);
        wait_until(a + 10);

        // Coordinate sums wrapping the port width
        issue(250, 3, 10, 1, 5, 1'b0, a);
        lit_x(a+6, 0); lit_p(a+6, 1'b0);
        wait_until(a + 12);
        issue(150, 118, 12, 12, 6, 1'b0, a);
        wait_until(a + 146);

        // Zero-size requests
        issue(5, 5, 0, 5, 1, 1'b0, a);
        lit_d(a, 1'b1);
        wait_until(a + 2);
        issue(5, 5, 7, 0, 1, 1'b0, a);
        lit_d(a, 1'b1); lit_d(a+1, 1'b0);
        wait_until(a + 3);

        // Request while busy is dropped; next accepted right after done
        issue(30, 40, 1, 3, 2, 1'b0, a);
        lit_x(a, 30); lit_x(a+2, 30); lit_y(a+2, 42);
        wait_until(a + 1);
        drive_inputs(99, 9, 1, 1, 7, 1'b0);
        bus.req = 1'b1;
        @(negedge clk);
        bus.req = 1'b0;
        wait_until(a + 4);
        issue(70, 71, 2, 1, 3, 1'b0, a2);
        lit_x(a2, 70); lit_y(a2, 71);
        wait_until(a2 + 4);

        // Reset in the middle of a 4x4 draw, then a 1x1
        issue(50, 60, 4, 4, 7, 1'b0, a);
        wait_until(a + 5);
        pulse_reset(1);
        issue(7, 8, 1, 1, 5, 1'b0, a);
        lit_x(a, 7); lit_y(a, 8); lit_p(a, 1'b1); lit_d(a+1, 1'b1);
        wait_until(a + 3);

        // Largest width and a tall column
        issue(0, 0, 255, 2, 1, 1'b0, a);
        lit_x(a+254, 254); lit_y(a+255, 1); lit_d(a+510, 1'b1);
        wait_until(a + 512);
        issue(159, 0, 1, 127, 3, 1'b0, a);
        wait_until(a + 129);

`ifdef RECT_OUTLINE_EN
        issue(20, 20, 3, 3, 4, 1'b1, a);
        lit_p(a+3, 1'b1); lit_p(a+4, 1'b0); lit_p(a+5, 1'b1); lit_d(a+9, 1'b1);
        wait_until(a + 11);
        issue(20, 20, 3, 3, 4, 1'b0, a);
        lit_p(a+4, 1'b1); lit_d(a+9, 1'b1);
        wait_until(a + 11);
        issue(0, 0, 5, 4, 2, 1'b1, a);
        wait_until(a + 22);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
